// File: rtl/tlb_cp0_ctrl_pkg.sv
// Shared definitions for the CP0-side TLB controller: register numbers,
// tlb_config / entry field offsets, FSM states and EntryLo packing helper.
package tlb_cp0_ctrl_pkg;

    localparam logic [4:0] CP0_INDEX    = 5'd0;
    localparam logic [4:0] CP0_RANDOM   = 5'd1;
    localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
    localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
    localparam logic [4:0] CP0_WIRED    = 5'd6;
    localparam logic [4:0] CP0_ENTRYHI  = 5'd10;

    localparam logic [3:0] TLB_LAST_IDX = 4'd15;

    localparam int CFG_WIDTH   = 84;
    localparam int ENT_WIDTH   = 80;

    // Entry offsets; tlb_config uses the same layout shifted up by the 4-bit index.
    localparam int ENT_ASID_LSB = 72;
    localparam int ENT_G        = 71;
    localparam int ENT_VPN2_LSB = 52;
    localparam int ENT_PFN1_LSB = 28;
    localparam int ENT_D1       = 27;
    localparam int ENT_V1       = 26;
    localparam int ENT_PFN0_LSB = 2;
    localparam int ENT_D0       = 1;
    localparam int ENT_V0       = 0;
    localparam int CFG_IDX_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } tlb_state_e;

    typedef struct packed {
        logic [23:0] pfn;
        logic        d;
        logic        v;
        logic        g;
    } entry_lo_t;

    // The cache attribute field is not stored and always reads back as zero.
    function automatic logic [31:0] packEntryLo(input entry_lo_t lo);
        return {2'b00, lo.pfn, 3'b000, lo.d, lo.v, lo.g};
    endfunction

endpackage

// File: rtl/tlb_cp0_ctrl_random.sv
// Random register: counts down each cycle, wrapping from Wired back to the
// last TLB index so wired entries are never chosen by TLBWR.
module tlb_random_ctr
    import tlb_cp0_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_wired,
    input  logic       i_wired_we,
    output logic [3:0] o_random
);

    logic [3:0] r_random;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_random <= TLB_LAST_IDX;
        end else if (i_wired_we || (r_random == i_wired)) begin
            r_random <= TLB_LAST_IDX;
        end else begin
            r_random <= r_random - 4'd1;
        end
    end

    assign o_random = r_random;

endmodule

// File: rtl/tlb_cp0_ctrl.sv
// CP0 TLB register file and TLBP/TLBR/TLBWI/TLBWR sequencer sitting between
// the MEM/WB CP0 access logic and the TLB array.
module tlb_cp0_ctrl
    import tlb_cp0_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_mtc0_we,
    input  logic [4:0]           i_mtc0_addr,
    input  logic [31:0]          i_mtc0_data,
    input  logic [4:0]           i_mfc0_addr,
    output logic [31:0]          o_mfc0_data,
    input  logic                 i_op_tlbp,
    input  logic                 i_op_tlbr,
    input  logic                 i_op_tlbwi,
    input  logic                 i_op_tlbwr,
    output logic                 o_busy,
    output logic [CFG_WIDTH-1:0] o_tlb_config,
    output logic                 o_tlbwi,
    output logic                 o_tlbp,
    input  logic [31:0]          i_tlbp_result,
    output logic [3:0]           o_tlb_rd_index,
    input  logic [ENT_WIDTH-1:0] i_tlb_rd_entry,
    output logic [7:0]           o_asid
);

    tlb_state_e r_state;
    logic       r_busy;
    logic       r_tlbwi;
    logic       r_tlbp;
    logic [3:0] r_sel;
    logic       r_sel_random;

    logic        r_index_p;
    logic [3:0]  r_index_idx;
    entry_lo_t   r_lo0;
    entry_lo_t   r_lo1;
    logic [3:0]  r_wired;
    logic [18:0] r_hi_vpn2;
    logic [7:0]  r_hi_asid;

    logic [3:0] w_random;
    logic       w_wired_we;
    logic [3:0] w_cfg_idx;
    logic       w_unused;

    assign w_wired_we = i_mtc0_we && (i_mtc0_addr == CP0_WIRED);
    assign w_unused   = ^i_tlbp_result[30:4];

    tlb_random_ctr u_random (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wired   (r_wired),
        .i_wired_we(w_wired_we),
        .o_random  (w_random)
    );

    // Commands are taken only in IDLE; every command occupies exactly one busy cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_tlbwi      <= 1'b0;
            r_tlbp       <= 1'b0;
            r_sel        <= 4'd0;
            r_sel_random <= 1'b0;
        end else begin
            r_tlbwi <= 1'b0;
            r_tlbp  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_op_tlbp) begin
                        r_state <= ST_PROBE;
                        r_busy  <= 1'b1;
                        r_tlbp  <= 1'b1;
                    end else if (i_op_tlbr) begin
                        r_state <= ST_READ;
                        r_busy  <= 1'b1;
                    end else if (i_op_tlbwi) begin
                        r_state      <= ST_WRITE;
                        r_busy       <= 1'b1;
                        r_tlbwi      <= 1'b1;
                        r_sel_random <= 1'b0;
                    end else if (i_op_tlbwr) begin
                        r_state      <= ST_WRITE;
                        r_busy       <= 1'b1;
                        r_tlbwi      <= 1'b1;
                        r_sel_random <= 1'b1;
                        r_sel        <= w_random;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_busy       <= 1'b0;
                    r_sel_random <= 1'b0;
                end
            endcase
        end
    end

    // Hardware captures are written after software writes so they take priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_index_p   <= 1'b0;
            r_index_idx <= 4'd0;
            r_lo0       <= '0;
            r_lo1       <= '0;
            r_wired     <= 4'd0;
            r_hi_vpn2   <= 19'd0;
            r_hi_asid   <= 8'd0;
        end else begin
            if (i_mtc0_we) begin
                case (i_mtc0_addr)
                    CP0_INDEX: begin
                        r_index_p   <= i_mtc0_data[31];
                        r_index_idx <= i_mtc0_data[3:0];
                    end
                    CP0_ENTRYLO0: r_lo0 <= {i_mtc0_data[29:6], i_mtc0_data[2:0]};
                    CP0_ENTRYLO1: r_lo1 <= {i_mtc0_data[29:6], i_mtc0_data[2:0]};
                    CP0_WIRED:    r_wired <= i_mtc0_data[3:0];
                    CP0_ENTRYHI: begin
                        r_hi_vpn2 <= i_mtc0_data[31:13];
                        r_hi_asid <= i_mtc0_data[7:0];
                    end
                    default: ;
                endcase
            end
            if (r_state == ST_PROBE) begin
                r_index_p   <= i_tlbp_result[31];
                r_index_idx <= i_tlbp_result[3:0];
            end
            if (r_state == ST_READ) begin
                r_hi_asid <= i_tlb_rd_entry[ENT_ASID_LSB +: 8];
                r_hi_vpn2 <= i_tlb_rd_entry[ENT_VPN2_LSB +: 19];
                r_lo0     <= {i_tlb_rd_entry[ENT_PFN0_LSB +: 24], i_tlb_rd_entry[ENT_D0],
                              i_tlb_rd_entry[ENT_V0], i_tlb_rd_entry[ENT_G]};
                r_lo1     <= {i_tlb_rd_entry[ENT_PFN1_LSB +: 24], i_tlb_rd_entry[ENT_D1],
                              i_tlb_rd_entry[ENT_V1], i_tlb_rd_entry[ENT_G]};
            end
        end
    end

    always_comb begin
        o_mfc0_data = 32'd0;
        case (i_mfc0_addr)
            CP0_INDEX:    o_mfc0_data = {r_index_p, 27'd0, r_index_idx};
            CP0_RANDOM:   o_mfc0_data = {28'd0, w_random};
            CP0_ENTRYLO0: o_mfc0_data = packEntryLo(r_lo0);
            CP0_ENTRYLO1: o_mfc0_data = packEntryLo(r_lo1);
            CP0_WIRED:    o_mfc0_data = {28'd0, r_wired};
            CP0_ENTRYHI:  o_mfc0_data = {r_hi_vpn2, 5'd0, r_hi_asid};
            default:      o_mfc0_data = 32'd0;
        endcase
    end

    // TLBWR uses the Random value latched at acceptance; otherwise the live Index.
    assign w_cfg_idx = r_sel_random ? r_sel : r_index_idx;

    assign o_tlb_config = {r_hi_asid, (r_lo0.g & r_lo1.g), r_hi_vpn2,
                           r_lo1.pfn, r_lo1.d, r_lo1.v,
                           r_lo0.pfn, r_lo0.d, r_lo0.v,
                           w_cfg_idx};

    assign o_busy         = r_busy;
    assign o_tlbwi        = r_tlbwi;
    assign o_tlbp         = r_tlbp;
    assign o_tlb_rd_index = r_index_idx;
    assign o_asid         = r_hi_asid;

endmodule

// File: tb/tb_tlb_cp0_ctrl.sv
// Directed self-checking bench for tlb_cp0_ctrl: reset, TLBWI/TLBP/TLBR/TLBWR,
// Random wrap, busy handling, collisions and reset abort.
module tb_tlb_cp0_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mtc0We;
    logic [4:0]  mtc0Addr;
    logic [31:0] mtc0Data;
    logic [4:0]  mfc0Addr;
    logic [31:0] mfc0Data;
    logic        opTlbp, opTlbr, opTlbwi, opTlbwr;
    logic        busy;
    logic [83:0] tlbConfig;
    logic        tlbwi, tlbp;
    logic [31:0] tlbpResult;
    logic [3:0]  tlbRdIndex;
    logic [79:0] tlbRdEntry;
    logic [7:0]  asid;

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    tlb_cp0_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_mtc0_we     (mtc0We),
        .i_mtc0_addr   (mtc0Addr),
        .i_mtc0_data   (mtc0Data),
        .i_mfc0_addr   (mfc0Addr),
        .o_mfc0_data   (mfc0Data),
        .i_op_tlbp     (opTlbp),
        .i_op_tlbr     (opTlbr),
        .i_op_tlbwi    (opTlbwi),
        .i_op_tlbwr    (opTlbwr),
        .o_busy        (busy),
        .o_tlb_config  (tlbConfig),
        .o_tlbwi       (tlbwi),
        .o_tlbp        (tlbp),
        .i_tlbp_result (tlbpResult),
        .o_tlb_rd_index(tlbRdIndex),
        .i_tlb_rd_entry(tlbRdEntry),
        .o_asid        (asid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [83:0] observed, input logic [83:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] data);
        mtc0We   = 1'b1;
        mtc0Addr = addr;
        mtc0Data = data;
        tick();
        mtc0We   = 1'b0;
    endtask

    task automatic checkReg(input string tag, input logic [4:0] addr, input logic [31:0] expected);
        mfc0Addr = addr;
        #1;
        checkOutput(tag, 84'(mfc0Data), 84'(expected));
    endtask

    initial begin
        rst_n = 1'b0;
        mtc0We = 1'b0; mtc0Addr = '0; mtc0Data = '0; mfc0Addr = '0;
        opTlbp = 1'b0; opTlbr = 1'b0; opTlbwi = 1'b0; opTlbwr = 1'b0;
        tlbpResult = '0; tlbRdEntry = '0;
        #12;
        checkReg("reset_random", 5'd1, 32'h0000000F);
        checkReg("reset_index", 5'd0, 32'h0);
        checkOutput("reset_busy", 84'(busy), 84'd0);
        checkOutput("reset_strobes", 84'({tlbwi, tlbp}), 84'd0);
        checkOutput("reset_config", tlbConfig, 84'd0);
        checkOutput("reset_rd_index", 84'(tlbRdIndex), 84'd0);
        rst_n = 1'b1;
        tick();

        // TLBWI
        applyStimulus(5'd10, 32'h12346005);
        applyStimulus(5'd2, 32'h00000447);
        applyStimulus(5'd3, 32'h0000048F);
        applyStimulus(5'd0, 32'h00000003);
        checkReg("lo0_readback", 5'd2, 32'h00000447);
        checkReg("lo1_readback", 5'd3, 32'h00000487);
        checkOutput("asid_out", 84'(asid), 84'h05);
        checkOutput("idle_no_wi", 84'(tlbwi), 84'd0);
        opTlbwi = 1'b1;
        tick();
        opTlbwi = 1'b0;
        checkOutput("tlbwi_strobe", 84'(tlbwi), 84'd1);
        checkOutput("tlbwi_busy", 84'(busy), 84'd1);
        checkOutput("tlbwi_config", tlbConfig,
                    {8'h05, 1'b1, 19'h091A3, 24'h12, 2'b11, 24'h11, 2'b11, 4'h3});
        tick();
        checkOutput("tlbwi_pulse_end", 84'({tlbwi, busy}), 84'd0);

        // TLBP hit then miss
        tlbpResult = 32'h00000007;
        opTlbp = 1'b1;
        tick();
        opTlbp = 1'b0;
        checkOutput("tlbp_strobe", 84'(tlbp), 84'd1);
        tick();
        checkOutput("tlbp_pulse_end", 84'(tlbp), 84'd0);
        checkReg("tlbp_hit_index", 5'd0, 32'h00000007);
        tlbpResult = 32'h80000000;
        opTlbp = 1'b1;
        tick();
        opTlbp = 1'b0;
        tick();
        checkReg("tlbp_miss_index", 5'd0, 32'h80000000);

        // TLBR
        applyStimulus(5'd0, 32'h00000009);
        tlbRdEntry = {8'hAA, 1'b1, 19'h7FFFF, 24'h1, 2'b10, 24'h2, 2'b01};
        opTlbr = 1'b1;
        tick();
        opTlbr = 1'b0;
        checkOutput("tlbr_rd_index", 84'(tlbRdIndex), 84'd9);
        checkOutput("tlbr_busy_no_strobe", 84'({busy, tlbwi, tlbp}), 84'b100);
        tick();
        checkReg("tlbr_entryhi", 5'd10, 32'hFFFFE0AA);
        checkReg("tlbr_entrylo0", 5'd2, 32'h00000083);
        checkReg("tlbr_entrylo1", 5'd3, 32'h00000045);

        // mtc0 in the accept cycle is visible to the command
        mtc0We = 1'b1; mtc0Addr = 5'd0; mtc0Data = 32'h00000005;
        opTlbwi = 1'b1;
        tick();
        mtc0We = 1'b0; opTlbwi = 1'b0;
        checkOutput("accept_cycle_write", tlbConfig,
                    {8'hAA, 1'b1, 19'h7FFFF, 24'h1, 2'b10, 24'h2, 2'b01, 4'h5});
        tick();

        // Probe capture beats a same-cycle Index write
        tlbpResult = 32'h0000000B;
        opTlbp = 1'b1;
        tick();
        opTlbp = 1'b0;
        applyStimulus(5'd0, 32'h00000002);
        checkReg("capture_wins", 5'd0, 32'h0000000B);

        // Probe arriving while busy is ignored
        opTlbwi = 1'b1;
        tick();
        opTlbwi = 1'b0;
        opTlbp = 1'b1;
        tlbpResult = 32'h00000004;
        tick();
        opTlbp = 1'b0;
        checkOutput("busy_ignore_strobe", 84'({tlbp, busy}), 84'd0);
        tick();
        checkReg("busy_ignore_index", 5'd0, 32'h0000000B);

        // Simultaneous probe and write: probe only
        opTlbp = 1'b1; opTlbwi = 1'b1;
        tlbpResult = 32'h0000000C;
        tick();
        opTlbp = 1'b0; opTlbwi = 1'b0;
        checkOutput("priority_strobes", 84'({tlbp, tlbwi}), 84'b10);
        tick();
        checkReg("priority_index", 5'd0, 32'h0000000C);

        // Random wrap with Wired = 13, then TLBWR at Random = 14
        applyStimulus(5'd6, 32'h0000000D);
        checkReg("wired_readback", 5'd6, 32'h0000000D);
        checkReg("random_after_wired", 5'd1, 32'h0000000F);
        tick();
        checkReg("random_14", 5'd1, 32'h0000000E);
        tick();
        checkReg("random_13", 5'd1, 32'h0000000D);
        tick();
        checkReg("random_wrap_15", 5'd1, 32'h0000000F);
        tick();
        checkReg("random_14_again", 5'd1, 32'h0000000E);
        opTlbwr = 1'b1;
        tick();
        opTlbwr = 1'b0;
        checkOutput("tlbwr_strobe", 84'(tlbwi), 84'd1);
        checkOutput("tlbwr_index", 84'(tlbConfig[3:0]), 84'hE);
        tick();
        checkOutput("tlbwr_index_restored", 84'(tlbConfig[3:0]), 84'hC);

        // Reset during READ aborts the capture
        tlbRdEntry = {8'h33, 1'b1, 19'h12345, 24'hABCDEF, 2'b11, 24'h654321, 2'b11};
        opTlbr = 1'b1;
        tick();
        opTlbr = 1'b0;
        checkOutput("abort_busy_before", 84'(busy), 84'd1);
        #2;
        rst_n = 1'b0;
        tick();
        checkOutput("abort_busy", 84'({busy, tlbwi, tlbp}), 84'd0);
        checkReg("abort_entryhi", 5'd10, 32'h0);
        checkReg("abort_entrylo0", 5'd2, 32'h0);
        checkOutput("abort_config", tlbConfig, 84'd0);
        rst_n = 1'b1;
        tick();
        checkReg("abort_entrylo1", 5'd3, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
